divmod: RTL and testbench
=========================

DIVMOD -- requirements
Module: divmod

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width in bits (legal range 4..64).
REQ-002 SHALL have port clk, input, 1, single rising-edge clock for all state.
REQ-003 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have port run, input, 1, start request; sampled only in IDLE or DONE.
REQ-005 SHALL have port signed_op, input, 1, selects two's-complement division; sampled with run.
REQ-006 SHALL have port A, input, WIDTH, dividend; sampled with run.
REQ-007 SHALL have port B, input, WIDTH, divisor; sampled with run.
REQ-008 SHALL have port quotient, output, WIDTH, A/B, truncated toward zero.
REQ-009 SHALL have port remainder, output, WIDTH, A - quotient*B.
REQ-010 SHALL have port ready, output, 1, high only in DONE.
REQ-011 SHALL have port busy, output, 1, high in CALC and FIX.
REQ-012 SHALL have port div_by_zero, output, 1, high in DONE when the captured B was 0.

Function
REQ-013 SHALL implement states IDLE, CALC, FIX and DONE.
REQ-014 SHALL, in IDLE or DONE with run=1, capture A, B and signed_op, load bit counter = WIDTH and enter CALC on the same edge.
REQ-015 SHALL, if the captured B is 0, bypass CALC and enter DONE on the next edge with quotient = all ones, remainder = A and div_by_zero=1.
REQ-016 SHALL, in CALC, perform one restoring shift-subtract step per cycle on operand magnitudes, decrement the counter, and enter FIX after WIDTH cycles.
REQ-017 SHALL, in FIX, apply sign correction (quotient negated iff sign(A) xor sign(B); remainder takes sign(A)) when signed, then enter DONE.
REQ-018 SHALL assert ready exactly WIDTH+2 edges after the edge that sampled run (B nonzero), and 1 edge after for B=0.
REQ-019 SHALL hold quotient, remainder and div_by_zero stable in DONE until the next accepted run; they SHALL be 0 in every other state.
REQ-020 SHALL ignore run while busy=1, without affecting the operation in progress.
REQ-021 SHALL, for a signed most-negative / -1, return quotient = most-negative and remainder = 0, with no flag.
REQ-022 SHALL, when run=1 in DONE, leave DONE on that edge (back-to-back operation, no IDLE cycle).
REQ-023 SHALL use WIDTH-wide datapath registers only; no result may depend on truncated intermediate carries.

Reset
REQ-024 SHALL, on any edge with reset=1, enter IDLE, clear all data registers and the counter, and drive quotient, remainder, ready, busy and div_by_zero to 0.
REQ-025 SHALL, on reset during CALC or FIX, abandon the operation; the first run after reset release starts a fresh division.

Configuration
REQ-026 SHALL honour macro DIVMOD_SIGNED_EN: when defined, signed_op selects signed division per REQ-017 and REQ-021.
REQ-027 SHALL, without DIVMOD_SIGNED_EN, ignore signed_op, treat all operands as unsigned, keep the FIX state as a one-cycle pass-through, and keep latency identical.

Verification
REQ-028 SHALL cover: WIDTH=32, unsigned 100/7 -> quotient=14, remainder=2, ready on edge 34 after run.
REQ-029 SHALL cover: B=0, A=0x1234 -> next edge DONE, quotient=0xFFFFFFFF, remainder=0x1234, div_by_zero=1.
REQ-030 SHALL cover: signed -7/2 (macro defined) -> quotient=0xFFFFFFFD, remainder=0xFFFFFFFF; signed 0x80000000/0xFFFFFFFF -> quotient=0x80000000, remainder=0.
REQ-031 SHALL cover: run pulsed with new operands mid-CALC -> ignored, first result unchanged; run held high in DONE -> next division starts with no idle cycle.
REQ-032 SHALL cover: reset asserted on CALC cycle 10 -> next edge IDLE with all outputs 0; a subsequent 9/3 -> quotient=3, remainder=0.
REQ-033 SHALL cover: macro undefined, signed_op=1, A=0xFFFFFFF9, B=2 -> unsigned result quotient=0x7FFFFFFC, remainder=1.

Source files
------------

// File: rtl/divmod.sv
// ---------------------------------------------------------------------------
// divmod -- iterative restoring divider producing quotient and remainder.
//
// One quotient bit is resolved per clock. A request is accepted in IDLE or
// DONE, the division runs in CALC, the sign of the results is fixed up in FIX,
// and the results are presented in DONE until the next accepted request.
// A zero divisor skips the iteration and reports div_by_zero.
//
// Configuration macro:
//   DIVMOD_SIGNED_EN  when defined, signed_op selects two's-complement
//                     division; when undefined, signed_op is ignored and all
//                     operands are unsigned (FIX remains a one-cycle pass).
//
// Parameters:
//   WIDTH        operand / result width in bits (4..64)
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous active-high reset
//   run          start request, accepted only in IDLE or DONE
//   signed_op    signed division select, sampled with run
//   A            dividend, sampled with run
//   B            divisor, sampled with run
//   quotient     A / B truncated toward zero (0 outside DONE)
//   remainder    A - quotient * B (0 outside DONE)
//   ready        high in DONE
//   busy         high in CALC and FIX
//   div_by_zero  high in DONE when the captured divisor was zero
// ---------------------------------------------------------------------------
module divmod #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             ready,
    output logic             busy,
    output logic             div_by_zero
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    // quo_r starts as the dividend magnitude and has quotient bits shifted in
    // from the bottom as dividend bits leave from the top.
    logic [WIDTH-1:0] quo_r;
    logic [WIDTH-1:0] rem_r;
    logic [WIDTH-1:0] div_r;
    logic             neg_q;
    logic             neg_r;
    logic             bz;
    logic             sgn;

`ifdef DIVMOD_SIGNED_EN
    assign sgn = signed_op;
`else
    logic unused_signed_op;
    assign unused_signed_op = signed_op;
    assign sgn              = 1'b0;
`endif

    function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] x);
        return ~x + WIDTH'(1);
    endfunction

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x,
                                                   input logic             en);
        return (en && x[WIDTH-1]) ? negate(x) : x;
    endfunction

    // Trial subtraction: the partial remainder gains one dividend bit, so it
    // is WIDTH+1 bits wide before comparison. When the subtraction succeeds
    // the true difference is below the divisor, so the low WIDTH bits of the
    // wrapped difference are exact.
    logic [WIDTH:0]   shifted;
    logic             fits;
    logic [WIDTH-1:0] rem_sub;

    assign shifted = {rem_r, quo_r[WIDTH-1]};
    assign fits    = (shifted >= {1'b0, div_r});
    assign rem_sub = shifted[WIDTH-1:0] - div_r;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (run) state_nxt = CALC;
            end
            CALC: begin
                // The counter-exhausted cycle hands over to FIX, so a nonzero
                // division spends WIDTH+1 cycles here.
                if (bz)            state_nxt = DONE;
                else if (cnt == '0) state_nxt = FIX;
            end
            FIX: begin
                state_nxt = DONE;
            end
            DONE: begin
                if (run) state_nxt = CALC;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt   <= '0;
            quo_r <= '0;
            rem_r <= '0;
            div_r <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            bz    <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (run) begin
                        // A zero divisor keeps the raw dividend so it can be
                        // returned unchanged as the remainder.
                        quo_r <= (B == '0) ? A : magnitude(A, sgn);
                        div_r <= magnitude(B, sgn);
                        rem_r <= '0;
                        cnt   <= CNT_W'(WIDTH);
                        bz    <= (B == '0);
                        neg_q <= sgn & (A[WIDTH-1] ^ B[WIDTH-1]);
                        neg_r <= sgn & A[WIDTH-1];
                    end
                end
                CALC: begin
                    if (bz) begin
                        quo_r <= '1;
                        rem_r <= quo_r;
                    end else if (cnt != '0) begin
                        quo_r <= {quo_r[WIDTH-2:0], fits};
                        rem_r <= fits ? rem_sub : shifted[WIDTH-1:0];
                        cnt   <= cnt - CNT_W'(1);
                    end
                end
                FIX: begin
                    if (neg_q) quo_r <= negate(quo_r);
                    if (neg_r) rem_r <= negate(rem_r);
                end
                default: ;
            endcase
        end
    end

    assign ready       = (state == DONE);
    assign busy        = (state == CALC) || (state == FIX);
    assign quotient    = ready ? quo_r : '0;
    assign remainder   = ready ? rem_r : '0;
    assign div_by_zero = ready & bz;

endmodule

// File: tb/tb_divmod.sv
// ---------------------------------------------------------------------------
// tb_divmod -- directed-vector bench for divmod (WIDTH = 32).
// The stimulus process queues the expected result of every accepted request;
// a monitor pops and compares whenever ready rises, rechecks held results
// while ready stays high, and checks that results read zero outside DONE.
// ---------------------------------------------------------------------------
module tb_divmod;

    localparam int W = 32;

    logic         clk       = 1'b0;
    logic         reset     = 1'b1;
    logic         run       = 1'b0;
    logic         signed_op = 1'b0;
    logic [W-1:0] A         = '0;
    logic [W-1:0] B         = '0;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         ready;
    logic         busy;
    logic         div_by_zero;

    divmod #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .run         (run),
        .signed_op   (signed_op),
        .A           (A),
        .B           (B),
        .quotient    (quotient),
        .remainder   (remainder),
        .ready       (ready),
        .busy        (busy),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
        int           edge0;
        int           lat;
    } exp_t;

    exp_t sb[$];

    int n_vec = 0;
    int n_mis = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_mis++;
            $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Drive one request; the sampling edge is the next posedge.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                         input logic [W-1:0] eq, input logic [W-1:0] er,
                         input logic edz, input int lat);
        exp_t e;
        @(negedge clk);
        A = a; B = b; signed_op = s; run = 1'b1;
        e.q = eq; e.r = er; e.dz = edz; e.edge0 = cyc + 1; e.lat = lat;
        sb.push_back(e);
        @(negedge clk);
        run = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            n_vec++;
            n_mis++;
            $display("FAIL timeout: %0d results outstanding, required 0", sb.size());
            sb.delete();
        end
        @(negedge clk);
    endtask

    // Monitor
    initial begin
        exp_t cur;
        logic rd_d = 1'b0;
        logic have = 1'b0;
        forever begin
            @(negedge clk);
            if (ready && !rd_d) begin
                if (sb.size() == 0) begin
                    n_vec++;
                    n_mis++;
                    $display("FAIL unexpected_ready: got ready=1, required no result pending");
                end else begin
                    cur  = sb.pop_front();
                    have = 1'b1;
                    chk("quotient", quotient, cur.q);
                    chk("remainder", remainder, cur.r);
                    chk("div_by_zero", div_by_zero, cur.dz);
                    chk("latency", cyc - cur.edge0, cur.lat);
                    chk("busy_in_done", busy, 0);
                end
            end else if (ready && have) begin
                chk("quotient_hold", quotient, cur.q);
                chk("remainder_hold", remainder, cur.r);
                chk("div_by_zero_hold", div_by_zero, cur.dz);
            end else if (!ready) begin
                chk("quotient_not_done", quotient, 0);
                chk("remainder_not_done", remainder, 0);
                chk("div_by_zero_not_done", div_by_zero, 0);
            end
            rd_d = ready;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at time %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        exp_t e;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_quotient", quotient, 0);
        chk("rst_remainder", remainder, 0);
        chk("rst_ready", ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_div_by_zero", div_by_zero, 0);
        reset = 1'b0;

        // Basic unsigned and divide-by-zero
        issue(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, 34);                        wait_done();
        issue(32'h0000_1234, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'h0000_1234, 1'b1, 1);   wait_done();
        issue(32'hFFFF_FFFF, 32'd1, 1'b0, 32'hFFFF_FFFF, 32'd0, 1'b0, 34);          wait_done();
        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'd1, 32'd0, 1'b0, 34);          wait_done();
        issue(32'd5, 32'd10, 1'b0, 32'd0, 32'd5, 1'b0, 34);                          wait_done();
        issue(32'h8000_0000, 32'd3, 1'b0, 32'h2AAA_AAAA, 32'd2, 1'b0, 34);          wait_done();
        issue(32'hDEAD_BEEF, 32'h10, 1'b0, 32'h0DEA_DBEE, 32'hF, 1'b0, 34);         wait_done();
        issue(32'hFFFF_FFF9, 32'd2, 1'b0, 32'h7FFF_FFFC, 32'd1, 1'b0, 34);          wait_done();

`ifdef DIVMOD_SIGNED_EN
        issue(32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 34);  wait_done();
        issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, 1'b0, 34);  wait_done();
        issue(32'd7, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1, 1'b0, 34);          wait_done();
        issue(32'hFFFF_FFF9, 32'hFFFF_FFFE, 1'b1, 32'd3, 32'hFFFF_FFFF, 1'b0, 34);  wait_done();
        issue(32'hFFFF_FFFB, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b1, 1);   wait_done();
`else
        issue(32'hFFFF_FFF9, 32'd2, 1'b1, 32'h7FFF_FFFC, 32'd1, 1'b0, 34);          wait_done();
        issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'd0, 32'h8000_0000, 1'b0, 34);  wait_done();
`endif

        // run pulsed mid-CALC is ignored
        issue(32'd1000, 32'd33, 1'b0, 32'd30, 32'd10, 1'b0, 34);
        repeat (4) @(negedge clk);
        chk("busy_mid_calc", busy, 1);
        A = 32'd7; B = 32'd1; run = 1'b1;
        @(negedge clk);
        run = 1'b0; A = '0; B = '0;
        wait_done();

        // run held high through DONE restarts with no idle cycle
        @(negedge clk);
        A = 32'd50; B = 32'd5; signed_op = 1'b0; run = 1'b1;
        e.q = 32'd10; e.r = 32'd0; e.dz = 1'b0; e.edge0 = cyc + 1; e.lat = 34;
        sb.push_back(e);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ready && n < 100);
        A = 32'd83; B = 32'd9;
        e.q = 32'd9; e.r = 32'd2; e.dz = 1'b0; e.edge0 = cyc + 1; e.lat = 34;
        sb.push_back(e);
        @(negedge clk);
        run = 1'b0;
        wait_done();

        // reset on CALC cycle 10 abandons the operation
        @(negedge clk);
        A = 32'd12345; B = 32'd7; signed_op = 1'b0; run = 1'b1;
        @(negedge clk);
        run = 1'b0;
        repeat (9) @(negedge clk);
        chk("busy_before_abort", busy, 1);
        reset = 1'b1;
        @(negedge clk);
        chk("abort_quotient", quotient, 0);
        chk("abort_remainder", remainder, 0);
        chk("abort_ready", ready, 0);
        chk("abort_busy", busy, 0);
        chk("abort_div_by_zero", div_by_zero, 0);
        reset = 1'b0;
        issue(32'd9, 32'd3, 1'b0, 32'd3, 32'd0, 1'b0, 34);
        wait_done();

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
